// File: rtl/instr_mem_loader_if.sv
// Load-stream and fetch-port bundle for instr_mem_loader.
//   master : boot block / testbench / core side (drives ld_*, fetch_*)
//   slave  : the instruction memory
// Signals:
//   ld_valid, ld_addr, ld_data, ld_last  -> load word offer (master to slave)
//   ld_ready, ld_err                     <- load accept / sticky dropped-address flag
//   run                                  <- memory is serving fetches
//   fetch_req, fetch_addr, fetch_stall   -> fetch request side
//   instr, instr_valid, fetch_err        <- registered fetch result
interface instr_mem_loader_if #(
  parameter int IW = 19,
  parameter int AW = 12
);
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [IW-1:0] ld_data;
  logic          ld_last;
  logic          ld_err;
  logic          run;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_stall;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic          fetch_err;

  modport master (
    output ld_valid, ld_addr, ld_data, ld_last, fetch_req, fetch_addr, fetch_stall,
    input  ld_ready, ld_err, run, instr, instr_valid, fetch_err
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data, ld_last, fetch_req, fetch_addr, fetch_stall,
    output ld_ready, ld_err, run, instr, instr_valid, fetch_err
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction memory with in-circuit program loading and a registered fetch port.
// After reset the array is cleared (DEPTH cycles), a program is accepted over the
// valid/ready load stream until a beat with ld_last, then fetches are served with
// one cycle of latency until the next reset.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : instr_mem_loader_if.slave (load stream, status, fetch port)
module instr_mem_loader #(
  parameter int IW    = 19,
  parameter int AW    = 12,
  parameter int DEPTH = 4096
) (
  input  logic                clk,
  input  logic                rst,
  instr_mem_loader_if.slave   bus
);

  // Array index width; addresses are range-checked on the full AW bits first.
  localparam int              DW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]     DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]   CLR_LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {S_CLEAR, S_LOAD, S_RUN} state_t;

  state_t        state, state_n;
  logic [AW-1:0] cnt;
  logic [IW-1:0] mem [DEPTH];

  logic          mem_we;
  logic [DW-1:0] mem_waddr;
  logic [IW-1:0] mem_wdata;
  logic          err_set;
  logic          ld_in_range;
  logic          fetch_in_range;
  logic          ld_err_q;
  logic [IW-1:0] instr_q;
  logic          instr_valid_q;
  logic          fetch_err_q;

  assign ld_in_range    = {1'b0, bus.ld_addr}    < DEPTH_W;
  assign fetch_in_range = {1'b0, bus.fetch_addr} < DEPTH_W;

  assign bus.ld_ready    = (state == S_LOAD);
  assign bus.run         = (state == S_RUN);
  assign bus.ld_err      = ld_err_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.fetch_err   = fetch_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (state == S_CLEAR) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    mem_we    = 1'b0;
    mem_waddr = cnt[DW-1:0];
    mem_wdata = '0;
    err_set   = 1'b0;
    unique case (state)
      S_CLEAR: begin
        mem_we = 1'b1;
        if (cnt == CLR_LAST) state_n = S_LOAD;
      end
      S_LOAD: begin
        // ld_ready is 1 throughout LOAD, so ld_valid alone marks a transfer.
        if (bus.ld_valid) begin
          if (ld_in_range) begin
            mem_we    = 1'b1;
            mem_waddr = bus.ld_addr[DW-1:0];
            mem_wdata = bus.ld_data;
          end else begin
            err_set = 1'b1;
          end
          if (bus.ld_last) state_n = S_RUN;
        end
      end
      S_RUN: ;
      default: state_n = S_CLEAR;
    endcase
    // The array has no reset; keep it untouched while reset is held.
    if (rst) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ld_err_q <= 1'b0;
    else if (err_set) ld_err_q <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else if (state == S_RUN && !bus.fetch_stall) begin
      if (bus.fetch_req) begin
        instr_valid_q <= 1'b1;
        if (fetch_in_range) begin
          instr_q     <= mem[bus.fetch_addr[DW-1:0]];
          fetch_err_q <= 1'b0;
        end else begin
          instr_q     <= '0;
          fetch_err_q <= 1'b1;
        end
      end else begin
        instr_valid_q <= 1'b0;
        fetch_err_q   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;
  localparam int IW    = 19;
  localparam int AW    = 5;
  localparam int DEPTH = 16;

  logic clk;
  logic rst;
  int unsigned n_cmp;
  int unsigned n_fail;

  instr_mem_loader_if #(.IW(IW), .AW(AW)) bus ();

  instr_mem_loader #(.IW(IW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_beat(input logic [AW-1:0] a, input logic [IW-1:0] d, input logic last);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = a;
    bus.ld_data  = d;
    bus.ld_last  = last;
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  // Junk on the load bus with ld_valid low; must have no effect.
  task automatic idle_beat(input logic [AW-1:0] a);
    bus.ld_valid = 1'b0;
    bus.ld_addr  = a;
    bus.ld_data  = 19'h3ABCD;
    bus.ld_last  = 1'b1;
    tick();
    bus.ld_last  = 1'b0;
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    bus.fetch_req   = 1'b1;
    bus.fetch_addr  = a;
    bus.fetch_stall = 1'b0;
    tick();
  endtask

  task automatic fetch_idle();
    bus.fetch_req   = 1'b0;
    bus.fetch_stall = 1'b0;
    tick();
  endtask

  // Release reset and count edges until ld_ready rises (expect DEPTH).
  task automatic release_and_clear(input string tag);
    int unsigned n;
    rst = 1'b0;
    n = 0;
    while (bus.ld_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n != 16) begin
      n_fail++;
      $display("FAIL %s clear_len: got %0d edges, expected 16", tag, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0; bus.ld_last = 1'b0;
    bus.fetch_req = 1'b0; bus.fetch_addr = '0; bus.fetch_stall = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({bus.ld_ready, bus.ld_err, bus.run, bus.instr_valid, bus.fetch_err, bus.instr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b err=%b run=%b v=%b ferr=%b instr=%h, expected all 0",
               bus.ld_ready, bus.ld_err, bus.run, bus.instr_valid, bus.fetch_err, bus.instr);
    end
    release_and_clear("first");
    n_cmp++;
    if ({bus.run, bus.ld_err} !== 2'b00) begin
      n_fail++;
      $display("FAIL load_entry: run=%b ld_err=%b, expected 0 0", bus.run, bus.ld_err);
    end
  endtask

  task automatic test_load_stream();
    // Request fetches during LOAD: must be ignored.
    bus.fetch_req = 1'b1; bus.fetch_addr = 5'd7;
    load_beat(5'd7, 19'h0A2C6, 1'b0);
    idle_beat(5'd6);
    load_beat(5'd8, 19'h1861F, 1'b0);
    idle_beat(5'd6);
    n_cmp++;
    if ({bus.ld_ready, bus.run, bus.instr_valid, bus.ld_err} !== 4'b1000) begin
      n_fail++;
      $display("FAIL mid_load: rdy=%b run=%b v=%b err=%b, expected 1 0 0 0",
               bus.ld_ready, bus.run, bus.instr_valid, bus.ld_err);
    end
    load_beat(5'd20, 19'h7FFFF, 1'b1);
    bus.fetch_req = 1'b0;
    n_cmp++;
    if ({bus.ld_ready, bus.run, bus.ld_err} !== 3'b011) begin
      n_fail++;
      $display("FAIL after_last: rdy=%b run=%b err=%b, expected 0 1 1",
               bus.ld_ready, bus.run, bus.ld_err);
    end
  endtask

  task automatic test_back_to_back();
    fetch(5'd7);
    n_cmp++;
    if ({bus.instr_valid, bus.fetch_err, bus.instr} !== {2'b10, 19'h0A2C6}) begin
      n_fail++;
      $display("FAIL b2b_7: v=%b ferr=%b instr=%h, expected 1 0 0a2c6", bus.instr_valid, bus.fetch_err, bus.instr);
    end
    fetch(5'd8);
    n_cmp++;
    if ({bus.instr_valid, bus.fetch_err, bus.instr} !== {2'b10, 19'h1861F}) begin
      n_fail++;
      $display("FAIL b2b_8: v=%b ferr=%b instr=%h, expected 1 0 1861f", bus.instr_valid, bus.fetch_err, bus.instr);
    end
    fetch_idle();
    n_cmp++;
    if ({bus.instr_valid, bus.fetch_err, bus.instr} !== {2'b00, 19'h1861F}) begin
      n_fail++;
      $display("FAIL b2b_idle: v=%b ferr=%b instr=%h, expected 0 0 1861f", bus.instr_valid, bus.fetch_err, bus.instr);
    end
  endtask

  task automatic test_unloaded();
    fetch(5'd9);
    n_cmp++;
    if ({bus.instr_valid, bus.fetch_err, bus.instr} !== {2'b10, 19'h0}) begin
      n_fail++;
      $display("FAIL unloaded_9: v=%b ferr=%b instr=%h, expected 1 0 0", bus.instr_valid, bus.fetch_err, bus.instr);
    end
    fetch(5'd6);
    n_cmp++;
    if (bus.instr !== 19'h0) begin
      n_fail++;
      $display("FAIL junk_6: instr=%h, expected 0", bus.instr);
    end
  endtask

  task automatic test_stall();
    fetch(5'd7);
    bus.fetch_stall = 1'b1;
    bus.fetch_addr  = 5'd8;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({bus.instr_valid, bus.instr} !== {1'b1, 19'h0A2C6}) begin
        n_fail++;
        $display("FAIL stall_%0d: v=%b instr=%h, expected 1 0a2c6", i, bus.instr_valid, bus.instr);
      end
    end
    bus.fetch_stall = 1'b0;
    tick();
    n_cmp++;
    if ({bus.instr_valid, bus.instr} !== {1'b1, 19'h1861F}) begin
      n_fail++;
      $display("FAIL stall_release: v=%b instr=%h, expected 1 1861f", bus.instr_valid, bus.instr);
    end
  endtask

  task automatic test_out_of_range();
    fetch(5'd31);
    n_cmp++;
    if ({bus.instr_valid, bus.fetch_err, bus.instr} !== {2'b11, 19'h0}) begin
      n_fail++;
      $display("FAIL oor_31: v=%b ferr=%b instr=%h, expected 1 1 0", bus.instr_valid, bus.fetch_err, bus.instr);
    end
    fetch(5'd8);
    fetch(5'd16);
    n_cmp++;
    if ({bus.instr_valid, bus.fetch_err, bus.instr} !== {2'b11, 19'h0}) begin
      n_fail++;
      $display("FAIL oor_16: v=%b ferr=%b instr=%h, expected 1 1 0", bus.instr_valid, bus.fetch_err, bus.instr);
    end
    fetch_idle();
    n_cmp++;
    if ({bus.instr_valid, bus.fetch_err} !== 2'b00) begin
      n_fail++;
      $display("FAIL oor_idle: v=%b ferr=%b, expected 0 0", bus.instr_valid, bus.fetch_err);
    end
  endtask

  task automatic test_reset_in_run();
    fetch(5'd8);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.ld_ready, bus.ld_err, bus.run, bus.instr_valid, bus.fetch_err, bus.instr} !== '0) begin
      n_fail++;
      $display("FAIL rst_run: rdy=%b err=%b run=%b v=%b ferr=%b instr=%h, expected all 0",
               bus.ld_ready, bus.ld_err, bus.run, bus.instr_valid, bus.fetch_err, bus.instr);
    end
    bus.fetch_req = 1'b0;
    tick();
    release_and_clear("run");
    load_beat(5'd3, 19'h12345, 1'b0);
    idle_beat(5'd7);
    load_beat(5'd5, 19'h2C0DE, 1'b0);
    idle_beat(5'd7);
    load_beat(5'd3, 19'h54321, 1'b1);
    n_cmp++;
    if ({bus.run, bus.ld_err} !== 2'b10) begin
      n_fail++;
      $display("FAIL reload_status: run=%b ld_err=%b, expected 1 0", bus.run, bus.ld_err);
    end
    fetch(5'd3);
    n_cmp++;
    if (bus.instr !== 19'h54321) begin
      n_fail++;
      $display("FAIL rewrite_3: instr=%h, expected 54321", bus.instr);
    end
    fetch(5'd5);
    n_cmp++;
    if (bus.instr !== 19'h2C0DE) begin
      n_fail++;
      $display("FAIL reload_5: instr=%h, expected 2c0de", bus.instr);
    end
    fetch(5'd7);
    n_cmp++;
    if ({bus.instr_valid, bus.instr} !== {1'b1, 19'h0}) begin
      n_fail++;
      $display("FAIL recleared_7: v=%b instr=%h, expected 1 0", bus.instr_valid, bus.instr);
    end
    fetch_idle();
  endtask

  task automatic test_reset_mid_load();
    rst = 1'b1;
    tick();
    release_and_clear("load");
    load_beat(5'd3, 19'h11111, 1'b0);
    load_beat(5'd4, 19'h22222, 1'b0);
    load_beat(5'd20, 19'h33333, 1'b0);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.ld_ready, bus.ld_err, bus.run, bus.instr_valid, bus.fetch_err, bus.instr} !== '0) begin
      n_fail++;
      $display("FAIL rst_load: rdy=%b err=%b run=%b v=%b ferr=%b instr=%h, expected all 0",
               bus.ld_ready, bus.ld_err, bus.run, bus.instr_valid, bus.fetch_err, bus.instr);
    end
    tick();
    release_and_clear("midload");
    load_beat(5'd0, 19'h00001, 1'b1);
    fetch(5'd3);
    n_cmp++;
    if (bus.instr !== 19'h0) begin
      n_fail++;
      $display("FAIL midload_3: instr=%h, expected 0", bus.instr);
    end
    fetch(5'd0);
    n_cmp++;
    if (bus.instr !== 19'h00001) begin
      n_fail++;
      $display("FAIL midload_0: instr=%h, expected 00001", bus.instr);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_load_stream();
    test_back_to_back();
    test_unloaded();
    test_stall();
    test_out_of_range();
    test_reset_in_run();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1);
  end

endmodule
